uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// uart_tx_frame
// UART transmit serializer fed by the APB register block. A frame is a start
// bit, 8 data bits LSB first, an optional parity bit and one or two stop bits.
// The bit period, parity mode and stop count are captured together with the
// byte, so the register block may be rewritten while a frame is in flight.
// Build option: define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry buffer in
// front of the serializer. Without it a byte is only taken while idle.
module uart_tx_frame #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       delitel,
  input  logic [3:0]        parity_bit_mode,
  input  logic [3:0]        stop_bit_num,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [31:0]         baud_q;
  logic [31:0]         last_q;
  logic [2:0]          bit_q;
  logic [DATA_W-1:0]   data_q;
  logic                par_en_q;
  logic                par_odd_q;
  logic                two_stop_q;
  logic                ready_en_q;
  logic                bit_end;
  logic                start_req;
  logic [DATA_W-1:0]   start_data;

  // The bit counter is 3 bits wide and the FIFO pointers wrap naturally, so
  // only an 8-bit frame and a power-of-two depth of at least 2 are supported.
  if (DATA_W != 8 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_frame: DATA_W must be 8 and FIFO_DEPTH a power of two >= 2");
  end

  // Last cycle of the current bit period (counter reached P-1).
  assign bit_end = (baud_q == last_q);
  assign busy    = (state_q != IDLE);

  // Holds tx_ready low while reset is asserted and until the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

`ifdef UART_TX_FIFO_EN
  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign tx_ready   = ready_en_q && !fifo_full;
  assign push       = tx_valid && tx_ready;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign start_req  = pop;
  assign start_data = fifo_mem[rd_ptr_q];

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; a push while full is never accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
`else
  assign tx_ready   = ready_en_q && (state_q == IDLE);
  assign start_req  = tx_valid && tx_ready;
  assign start_data = tx_data;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Baud and bit counters; byte and configuration are captured at frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q     <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      last_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (state_q == IDLE) begin
      baud_q <= '0;
      bit_q  <= '0;
      if (start_req) begin
        data_q     <= start_data;
        last_q     <= (delitel == 32'd0) ? 32'd0 : delitel - 32'd1;
        par_en_q   <= (parity_bit_mode == 4'd1) || (parity_bit_mode == 4'd2);
        par_odd_q  <= (parity_bit_mode == 4'd2);
        two_stop_q <= (stop_bit_num >= 4'd2);
      end
    end else begin
      baud_q <= bit_end ? 32'd0 : baud_q + 32'd1;
      if (state_q == DATA && bit_end) begin
        bit_q <= bit_q + 3'd1;
      end
    end
  end

  // Next-state decode plus the serial line and end-of-frame pulse.
  always_comb begin
    state_d    = state_q;
    tx         = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        tx = data_q[bit_q];
        if (bit_end && bit_q == 3'd7) begin
          state_d = par_en_q ? PARITY : STOP1;
        end
      end
      PARITY: begin
        tx = par_odd_q ? ~^data_q : ^data_q;
        if (bit_end) begin
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (bit_end) begin
          if (two_stop_q) begin
            state_d = STOP2;
          end else begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end
        end
      end
      STOP2: begin
        if (bit_end) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
// tb_uart_tx_frame
// Directed bench for uart_tx_frame. Inputs change and outputs are sampled on
// the falling clock edge. Waveforms are captured one bit per clock cycle,
// bit 0 being the first cycle after the byte enters the serializer.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] delitel;
  logic [3:0]  parity_bit_mode;
  logic [3:0]  stop_bit_num;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_BUILD = 1'b1;
`else
  localparam bit FIFO_BUILD = 1'b0;
`endif

  uart_tx_frame dut (
    .clk             (clk),
    .rst             (rst),
    .delitel         (delitel),
    .parity_bit_mode (parity_bit_mode),
    .stop_bit_num    (stop_bit_num),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready),
    .tx              (tx),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Repeats each frame bit (bit 0 sent first) for p cycles.
  function automatic logic [127:0] expand(input logic [15:0] bits, input int nbits, input int p);
    logic [127:0] w = '0;
    for (int j = 0; j < nbits; j++) begin
      for (int c = 0; c < p; c++) begin
        w[j * p + c] = bits[j];
      end
    end
    return w;
  endfunction

  function automatic logic [127:0] ones(input int n);
    return (128'(1) << n) - 128'(1);
  endfunction

  // Offers one byte, then scrambles tx_data; returns on the first frame cycle.
  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL send_ready: tx_ready=%b expected 1 (byte %h)", tx_ready, d);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
`ifdef UART_TX_FIFO_EN
    @(negedge clk);
`endif
  endtask

  // Records n cycles of the outputs; returns on cycle n+1.
  task automatic capture(input int n, output logic [127:0] txw, output logic [127:0] busyw,
                         output logic [127:0] donew, output logic [127:0] rdyw);
    txw   = '0;
    busyw = '0;
    donew = '0;
    rdyw  = '0;
    for (int i = 0; i < n; i++) begin
      txw[i]   = tx;
      busyw[i] = busy;
      donew[i] = frame_done;
      rdyw[i]  = tx_ready;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    tx_valid        = 1'b0;
    tx_data         = 8'h00;
    delitel         = 32'd4;
    parity_bit_mode = 4'd0;
    stop_bit_num    = 4'd1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
    n_checks++;
    if (tx_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ready: got %b expected 0", tx_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fails++; $display("[TB] FAIL idle_tx: got %b expected 1", tx); end
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL idle_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_basic();
    logic [127:0] txw, busyw, donew, rdyw, exp;
    delitel         = 32'd4;
    parity_bit_mode = 4'd0;
    stop_bit_num    = 4'd1;
    send_byte(8'hA5);
    capture(40, txw, busyw, donew, rdyw);
    exp = expand({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4);
    n_checks++;
    if (txw !== exp) begin n_fails++; $display("[TB] FAIL basic_tx: got %h expected %h", txw, exp); end
    n_checks++;
    if (busyw !== ones(40)) begin n_fails++; $display("[TB] FAIL basic_busy: got %h expected %h", busyw, ones(40)); end
    n_checks++;
    if (donew !== (128'(1) << 39)) begin n_fails++; $display("[TB] FAIL basic_done: got %h expected %h", donew, 128'(1) << 39); end
    n_checks++;
    if (rdyw !== (FIFO_BUILD ? ones(40) : 128'(0))) begin
      n_fails++;
      $display("[TB] FAIL basic_ready: got %h expected %h", rdyw, FIFO_BUILD ? ones(40) : 128'(0));
    end
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || frame_done !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL basic_after: tx=%b busy=%b ready=%b done=%b expected 1 0 1 0", tx, busy, tx_ready, frame_done);
    end
  endtask

  task automatic test_parity();
    logic [127:0] txw, busyw, donew, rdyw, exp;
    delitel         = 32'd2;
    stop_bit_num    = 4'd1;
    parity_bit_mode = 4'd1;
    send_byte(8'h07);
    capture(22, txw, busyw, donew, rdyw);
    exp = expand({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 2);
    n_checks++;
    if (txw !== exp) begin n_fails++; $display("[TB] FAIL even_tx: got %h expected %h", txw, exp); end
    n_checks++;
    if (donew !== (128'(1) << 21)) begin n_fails++; $display("[TB] FAIL even_done: got %h expected %h", donew, 128'(1) << 21); end
    n_checks++;
    if (busyw !== ones(22)) begin n_fails++; $display("[TB] FAIL even_busy: got %h expected %h", busyw, ones(22)); end
    parity_bit_mode = 4'd2;
    send_byte(8'h07);
    capture(22, txw, busyw, donew, rdyw);
    exp = expand({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 2);
    n_checks++;
    if (txw !== exp) begin n_fails++; $display("[TB] FAIL odd_tx: got %h expected %h", txw, exp); end
    n_checks++;
    if (donew !== (128'(1) << 21)) begin n_fails++; $display("[TB] FAIL odd_done: got %h expected %h", donew, 128'(1) << 21); end
    n_checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin n_fails++; $display("[TB] FAIL odd_after: busy=%b tx=%b expected 0 1", busy, tx); end
  endtask

  task automatic test_two_stop();
    logic [127:0] txw, busyw, donew, rdyw, exp;
    delitel         = 32'd0;
    parity_bit_mode = 4'd0;
    stop_bit_num    = 4'd2;
    send_byte(8'hFF);
    capture(11, txw, busyw, donew, rdyw);
    exp = expand({5'b0, 2'b11, 8'hFF, 1'b0}, 11, 1);
    n_checks++;
    if (txw !== exp) begin n_fails++; $display("[TB] FAIL stop2_tx: got %h expected %h", txw, exp); end
    n_checks++;
    if (busyw !== ones(11)) begin n_fails++; $display("[TB] FAIL stop2_busy: got %h expected %h", busyw, ones(11)); end
    n_checks++;
    if (donew !== (128'(1) << 10)) begin n_fails++; $display("[TB] FAIL stop2_done: got %h expected %h", donew, 128'(1) << 10); end
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL stop2_after: busy=%b expected 0", busy); end
  endtask

  task automatic test_config_change();
    logic [127:0] txa, busya, donea, rdya;
    logic [127:0] txb, busyb, doneb, rdyb;
    logic [127:0] exp;
    delitel         = 32'd8;
    parity_bit_mode = 4'd0;
    stop_bit_num    = 4'd1;
    send_byte(8'h96);
    capture(4, txa, busya, donea, rdya);
    delitel         = 32'd2;
    parity_bit_mode = 4'd1;
    stop_bit_num    = 4'd2;
    capture(76, txb, busyb, doneb, rdyb);
    txa   = txa | (txb << 4);
    busya = busya | (busyb << 4);
    donea = donea | (doneb << 4);
    exp   = expand({6'b0, 1'b1, 8'h96, 1'b0}, 10, 8);
    n_checks++;
    if (txa !== exp) begin n_fails++; $display("[TB] FAIL cfg_old_tx: got %h expected %h", txa, exp); end
    n_checks++;
    if (busya !== ones(80)) begin n_fails++; $display("[TB] FAIL cfg_old_busy: got %h expected %h", busya, ones(80)); end
    n_checks++;
    if (donea !== (128'(1) << 79)) begin n_fails++; $display("[TB] FAIL cfg_old_done: got %h expected %h", donea, 128'(1) << 79); end
    send_byte(8'h81);
    capture(24, txb, busyb, doneb, rdyb);
    exp = expand({4'b0, 2'b11, 1'b0, 8'h81, 1'b0}, 12, 2);
    n_checks++;
    if (txb !== exp) begin n_fails++; $display("[TB] FAIL cfg_new_tx: got %h expected %h", txb, exp); end
    n_checks++;
    if (doneb !== (128'(1) << 23)) begin n_fails++; $display("[TB] FAIL cfg_new_done: got %h expected %h", doneb, 128'(1) << 23); end
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] txw, busyw, donew, rdyw, exp;
    delitel         = 32'd4;
    parity_bit_mode = 4'd0;
    stop_bit_num    = 4'd1;
    send_byte(8'h00);
    repeat (17) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_pre: tx=%b busy=%b expected 0 1", tx, busy); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL mid_reset: tx=%b busy=%b done=%b expected 1 0 0", tx, busy, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL mid_release: ready=%b tx=%b busy=%b expected 1 1 0", tx_ready, tx, busy);
    end
    send_byte(8'h3C);
    capture(40, txw, busyw, donew, rdyw);
    exp = expand({6'b0, 1'b1, 8'h3C, 1'b0}, 10, 4);
    n_checks++;
    if (txw !== exp) begin n_fails++; $display("[TB] FAIL mid_next_tx: got %h expected %h", txw, exp); end
    n_checks++;
    if (donew !== (128'(1) << 39)) begin n_fails++; $display("[TB] FAIL mid_next_done: got %h expected %h", donew, 128'(1) << 39); end
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo();
    logic [7:0]   b [5] = '{8'hA5, 8'h3C, 8'h0F, 8'h81, 8'h7E};
    logic [127:0] w;
    logic [127:0] exp;
    logic [9:0]   fr;
    logic         acc;
    int           k;
    delitel         = 32'd1;
    parity_bit_mode = 4'd0;
    stop_bit_num    = 4'd1;
    @(negedge clk);
    k        = 0;
    w        = '0;
    tx_valid = 1'b1;
    tx_data  = b[0];
    for (int i = 0; i < 60; i++) begin
      acc = tx_valid && tx_ready;
      @(negedge clk);
      w[i] = tx;
      if (acc) begin
        k++;
        if (k == 5) begin
          tx_valid = 1'b0;
          tx_data  = 8'h00;
          n_checks++;
          if (tx_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL fifo_full_ready: got %b expected 0", tx_ready); end
        end else begin
          tx_data = b[k];
        end
      end
    end
    n_checks++;
    if (k != 5) begin n_fails++; $display("[TB] FAIL fifo_accepted: got %0d expected 5", k); end
    exp = ones(60);
    for (int f = 0; f < 5; f++) begin
      fr = {1'b1, b[f], 1'b0};
      for (int j = 0; j < 10; j++) begin
        exp[1 + 11 * f + j] = fr[j];
      end
    end
    n_checks++;
    if (w !== exp) begin n_fails++; $display("[TB] FAIL fifo_tx: got %h expected %h", w, exp); end
    n_checks++;
    if (busy !== 1'b0 || tx_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL fifo_after: busy=%b ready=%b expected 0 1", busy, tx_ready); end
  endtask
`endif

  // Runs every scenario in turn and prints the summary.
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_config_change();
    test_reset_mid_frame();
`ifdef UART_TX_FIFO_EN
    test_fifo();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Guards against a run that never reaches the summary.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
